// File: rtl/clk_gate_ctrl.sv
// Per-channel clock gating controller.
// Each channel runs its own OFF/WAKE/ON/DRAIN sequencer, plus a
// falling-edge hold register that makes its gated clock glitch-free.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   OFF   | clock gated off, waiting for REQ
//   WAKE  | clock running, wake timer counting down to ACK (REQ ignored)
//   ON    | clock running and stable, ACK asserted
//   DRAIN | REQ dropped; idle counter runs until IDLE_LIMIT, BUSY holds off
module clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TE,
    input  logic [NUM_CH-1:0] REQ,
    input  logic [NUM_CH-1:0] BUSY,
    input  logic [CNT_W-1:0]  IDLE_LIMIT,
    output logic [NUM_CH-1:0] ACK,
    output logic [NUM_CH-1:0] CLK_OUT
);

    // WAKE_CYC is at most 15, so four bits always hold the wake timer.
    localparam int               WK_W      = 4;
    localparam logic [WK_W-1:0]  WAKE_LOAD = WK_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = '1;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [WK_W-1:0]   wake_q  [NUM_CH];
    logic [WK_W-1:0]   wake_d  [NUM_CH];
    logic [CNT_W-1:0]  idle_q  [NUM_CH];
    logic [CNT_W-1:0]  idle_d  [NUM_CH];
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] hold_d;
    logic [NUM_CH-1:0] hold_q;

    // Next-state and counter logic for every channel sequencer.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            wake_d[i]  = wake_q[i];
            idle_d[i]  = idle_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (REQ[i]) begin
                        state_d[i] = ST_WAKE;
                        wake_d[i]  = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    // Terminal count on the down-counter ends the wake window.
                    if (wake_q[i] == '0) begin
                        state_d[i] = ST_ON;
                    end else begin
                        wake_d[i] = wake_q[i] - 1'b1;
                    end
                end
                ST_ON: begin
                    if (!REQ[i]) begin
                        state_d[i] = ST_DRAIN;
                        idle_d[i]  = '0;
                    end
                end
                ST_DRAIN: begin
                    if (REQ[i]) begin
                        state_d[i] = ST_ON;
                    end else if (BUSY[i]) begin
                        idle_d[i] = '0;
                    end else if (idle_q[i] >= IDLE_LIMIT) begin
                        state_d[i] = ST_OFF;
                    end else if (idle_q[i] != IDLE_MAX) begin
                        idle_d[i] = idle_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                end
            endcase
        end
    end

    // Sequencer state and counters, synchronous reset to OFF.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (RST) begin
                state_q[i] <= ST_OFF;
                wake_q[i]  <= '0;
                idle_q[i]  <= '0;
            end else begin
                state_q[i] <= state_d[i];
                wake_q[i]  <= wake_d[i];
                idle_q[i]  <= idle_d[i];
            end
        end
    end

    // ACK and gate enable decoded from the sequencer state; TE only opens the gate.
    always_comb begin
        ACK     = '0;
        gate_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ACK[i]     = (state_q[i] == ST_ON) || (state_q[i] == ST_DRAIN);
            gate_en[i] = (state_q[i] != ST_OFF) || TE;
        end
        hold_d = gate_en;
    end

    // Hold register updates while CLK is low so the AND gate never chops a pulse.
    always_ff @(negedge CLK) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign CLK_OUT = hold_q & {NUM_CH{CLK}};

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model of each channel.
module tb_clk_gate_ctrl;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int WAKE_CYC = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              TE  = 1'b0;
    logic [NUM_CH-1:0] REQ  = '0;
    logic [NUM_CH-1:0] BUSY = '0;
    logic [CNT_W-1:0]  IDLE_LIMIT = 8'd3;
    logic [NUM_CH-1:0] ACK;
    logic [NUM_CH-1:0] CLK_OUT;

    clk_gate_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TE         (TE),
        .REQ        (REQ),
        .BUSY       (BUSY),
        .IDLE_LIMIT (IDLE_LIMIT),
        .ACK        (ACK),
        .CLK_OUT    (CLK_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NUM_CH-1:0] ack;
        logic [NUM_CH-1:0] co;
        int                cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;
    bit   done     = 1'b0;
    int   cyc      = 0;

    // Behavioural model: clock enabled flag, cycles left until ACK,
    // draining flag and idle count per channel.
    bit en_m    [NUM_CH];
    int wake_rem[NUM_CH];
    bit drain_m [NUM_CH];
    int idle_m  [NUM_CH];

    task automatic chk(input string name, input logic [NUM_CH-1:0] act,
                       input logic [NUM_CH-1:0] exp, input int c);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    endtask

    // One clock cycle: advance the model with the inputs sampled at this edge.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            // Pulse at this edge reflects the gate captured on the previous falling edge.
            e.co[i] = RST ? 1'b0 : (en_m[i] | TE);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (RST) begin
                en_m[i] = 0; wake_rem[i] = 0; drain_m[i] = 0; idle_m[i] = 0;
            end else if (!en_m[i]) begin
                if (REQ[i]) begin en_m[i] = 1; wake_rem[i] = WAKE_CYC; end
            end else if (wake_rem[i] > 0) begin
                wake_rem[i]--;
            end else if (!drain_m[i]) begin
                if (!REQ[i]) begin drain_m[i] = 1; idle_m[i] = 0; end
            end else if (REQ[i]) begin
                drain_m[i] = 0;
            end else if (BUSY[i]) begin
                idle_m[i] = 0;
            end else if (idle_m[i] >= int'(IDLE_LIMIT)) begin
                en_m[i] = 0; drain_m[i] = 0;
            end else if (idle_m[i] < (1 << CNT_W) - 1) begin
                idle_m[i]++;
            end
        end
        for (int i = 0; i < NUM_CH; i++) e.ack[i] = en_m[i] && (wake_rem[i] == 0);
        e.cyc = cyc;
        if (chk_en) q.push_back(e);
        #2;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Monitor: compares ACK/CLK_OUT in the high phase, and CLK_OUT low in the low phase.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (chk_en) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty cycle %0d: got no entry expected one", cyc);
                end else begin
                    e = q.pop_front();
                    chk("ack", ACK, e.ack, e.cyc);
                    chk("clk_out_high", CLK_OUT, e.co, e.cyc);
                end
            end
            @(negedge CLK);
            #1;
            if (chk_en) chk("clk_out_low", CLK_OUT, '0, cyc);
        end
    end

    // Stimulus: directed scenarios then randomized traffic.
    initial begin
        steps(2);
        chk_en = 1'b1;
        steps(1);
        RST = 1'b0;
        steps(3);

        // Wake-up of channel 0.
        REQ = 4'b0001;
        steps(6);

        // Channel 1: on, then drain with IDLE_LIMIT=3 and no activity.
        IDLE_LIMIT = 8'd3;
        REQ = 4'b0011;
        steps(5);
        REQ = 4'b0001;
        steps(8);

        // Channel 2: BUSY pulse in DRAIN at count 2 restarts the idle count.
        REQ = 4'b0101;
        steps(5);
        REQ = 4'b0001;
        steps(3);
        BUSY = 4'b0100;
        steps(1);
        BUSY = 4'b0000;
        steps(8);

        // Channel 3: re-request during DRAIN.
        REQ = 4'b1001;
        steps(5);
        REQ = 4'b0001;
        steps(2);
        REQ = 4'b1001;
        steps(4);
        REQ = 4'b0000;
        steps(8);

        // Test enable with no requests; IDLE_LIMIT=0 edge case after.
        TE = 1'b1;
        steps(5);
        TE = 1'b0;
        IDLE_LIMIT = 8'd0;
        REQ = 4'b0010;
        steps(5);
        REQ = 4'b0000;
        steps(3);

        // Reset while ON, then re-wake only on request.
        REQ = 4'b0001;
        steps(5);
        RST = 1'b1;
        steps(1);
        RST = 1'b0;
        REQ = 4'b0000;
        steps(3);
        REQ = 4'b0001;
        steps(5);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 99) < 8) REQ[i] = ~REQ[i];
                BUSY[i] = ($urandom_range(0, 99) < 10);
            end
            if ($urandom_range(0, 63) == 0) IDLE_LIMIT = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 3) TE = ~TE;
            RST = ($urandom_range(0, 199) == 0);
            step();
        end

        RST = 1'b0;
        steps(1);
        chk_en = 1'b0;
        @(posedge CLK);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
